// File: rtl/pipe_out_block_reader.sv
// pipe_out_block_reader
//
// Drains the 32-bit read side of the pipe-out FIFO into a block-throttled
// host pipe-out endpoint. ep_ready is raised only once a whole block is
// sitting in the FIFO. Each block is sequenced by a word counter. Underrun
// and protocol violations are reported on sticky flags.
//
// Handshake: the host may issue ep_read only while a block is in flight
// (BURST). It may issue ep_blockstrobe only while ep_ready is high (ARMED).
// Each asserted ep_read cycle consumes exactly one word. The matching word
// appears on ep_datain in the following cycle. Any strobe or read outside
// its legal state is ignored and raises protocol_err.
//
// Optional build macro: PIPE_OUT_BLOCK_STATS_EN adds the blocks_sent and
// underrun_words statistics outputs.
//
// Ports:
//   okClk          clock (FIFO read side and endpoint)
//   reset_n        asynchronous active-low reset
//   fifo_dout      FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty     FIFO empty flag
//   fifo_valid     FIFO read-data valid
//   fifo_rd_count  FIFO read-side word count
//   fifo_rd_en     FIFO read enable (combinational)
//   ep_read        host read strobe, one word per asserted cycle
//   ep_blockstrobe host block-start pulse
//   ep_ready       a full block is buffered and armed
//   ep_datain      word to host
//   block_done     one-cycle pulse when a block completes
//   underrun       sticky: read issued while FIFO empty
//   protocol_err   sticky: read or strobe outside its legal state
//   clear_err      synchronous clear of the sticky flags
//   state_dbg      current FSM state (IDLE=0, ARMED=1, BURST=2, DONE=3)
//   blocks_sent    (stats build) completed blocks, wrapping
//   underrun_words (stats build) underrun reads, saturating

module pipe_out_block_reader #(
    parameter int                DATA_W      = 32,
    parameter int                BLOCK_WORDS = 128,
    parameter int                COUNT_W     = 10,
    parameter logic [DATA_W-1:0] FILL_WORD   = 32'hDEADBEEF
) (
    input  logic               okClk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  fifo_dout,
    input  logic               fifo_empty,
    input  logic               fifo_valid,
    input  logic [COUNT_W-1:0] fifo_rd_count,
    output logic               fifo_rd_en,
    input  logic               ep_read,
    input  logic               ep_blockstrobe,
    output logic               ep_ready,
    output logic [DATA_W-1:0]  ep_datain,
    output logic               block_done,
    output logic               underrun,
    output logic               protocol_err,
    input  logic               clear_err,
    output logic [1:0]         state_dbg
`ifdef PIPE_OUT_BLOCK_STATS_EN
    ,
    output logic [15:0]        blocks_sent,
    output logic [15:0]        underrun_words
`endif
);

    localparam int CNT_W = $clog2(BLOCK_WORDS + 1);
    localparam logic [COUNT_W-1:0] BLOCK_CNT = COUNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   word_cnt;
    logic               rd_pending;   // a FIFO read was issued last cycle
    logic               fill_sel;     // last cycle was an underrun read
    logic [DATA_W-1:0]  held_word;    // value shown when nothing new arrives
    logic               in_burst;
    logic               rd_ok;
    logic               ur_read;
    logic               strobe_ok;
    logic               proto_evt;

    assign state_dbg = state;

    // Event decode and next-state logic
    always_comb begin
        state_n    = state;
        in_burst   = (state == S_BURST);
        rd_ok      = ep_read && in_burst;
        ur_read    = rd_ok && fifo_empty;
        fifo_rd_en = rd_ok && !fifo_empty;
        strobe_ok  = ep_blockstrobe && (state == S_ARMED);
        proto_evt  = (ep_read && !in_burst) ||
                     (ep_blockstrobe && (state != S_ARMED));
        case (state)
            S_IDLE:  if (fifo_rd_count >= BLOCK_CNT) state_n = S_ARMED;
            S_ARMED: if (ep_blockstrobe) state_n = S_BURST;
            // The read that brings the counter to BLOCK_WORDS ends the burst.
            S_BURST: if (ep_read && (word_cnt == LAST_IDX)) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // rd_pending qualifies fifo_valid so that a stale valid from the FIFO
    // (e.g. across a reset of this block) never reaches the host.
    always_comb begin
        ep_datain = held_word;
        if (rd_pending && fifo_valid) ep_datain = fifo_dout;
        else if (fill_sel)            ep_datain = FILL_WORD;
    end

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            word_cnt     <= '0;
            ep_ready     <= 1'b0;
            block_done   <= 1'b0;
            underrun     <= 1'b0;
            protocol_err <= 1'b0;
            rd_pending   <= 1'b0;
            fill_sel     <= 1'b0;
            held_word    <= '0;
        end else begin
            state      <= state_n;
            // Registered from next state so they track ARMED / DONE exactly.
            ep_ready   <= (state_n == S_ARMED);
            block_done <= (state_n == S_DONE);
            if (strobe_ok)  word_cnt <= '0;
            else if (rd_ok) word_cnt <= word_cnt + 1'b1;
            rd_pending <= fifo_rd_en;
            fill_sel   <= ur_read;
            held_word  <= ep_datain;
            // Set has priority over clear.
            if (ur_read)        underrun <= 1'b1;
            else if (clear_err) underrun <= 1'b0;
            if (proto_evt)      protocol_err <= 1'b1;
            else if (clear_err) protocol_err <= 1'b0;
        end
    end

`ifdef PIPE_OUT_BLOCK_STATS_EN
    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            blocks_sent    <= '0;
            underrun_words <= '0;
        end else begin
            // Counts the block_done pulse (state DONE); wraps naturally.
            if (state == S_DONE) blocks_sent <= blocks_sent + 16'd1;
            // A simultaneous underrun read is still counted after the clear.
            if (clear_err)
                underrun_words <= ur_read ? 16'd1 : 16'd0;
            else if (ur_read && (underrun_words != 16'hFFFF))
                underrun_words <= underrun_words + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_out_block_reader.sv
// Directed bench for pipe_out_block_reader. A small behavioural FIFO
// (word queue, one-cycle read latency) feeds the DUT. An optional count
// override forces fifo_rd_count to chosen values.
module tb_pipe_out_block_reader;

    localparam logic [31:0] FILL = 32'hDEADBEEF;

    logic        okClk;
    logic        reset_n;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_valid;
    logic [9:0]  fifo_rd_count;
    logic        fifo_rd_en;
    logic        ep_read;
    logic        ep_blockstrobe;
    logic        ep_ready;
    logic [31:0] ep_datain;
    logic        block_done;
    logic        underrun;
    logic        protocol_err;
    logic        clear_err;
    logic [1:0]  state_dbg;
`ifdef PIPE_OUT_BLOCK_STATS_EN
    logic [15:0] blocks_sent;
    logic [15:0] underrun_words;
`endif

    pipe_out_block_reader dut (
        .okClk          (okClk),
        .reset_n        (reset_n),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_valid     (fifo_valid),
        .fifo_rd_count  (fifo_rd_count),
        .fifo_rd_en     (fifo_rd_en),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_ready       (ep_ready),
        .ep_datain      (ep_datain),
        .block_done     (block_done),
        .underrun       (underrun),
        .protocol_err   (protocol_err),
        .clear_err      (clear_err),
        .state_dbg      (state_dbg)
`ifdef PIPE_OUT_BLOCK_STATS_EN
        ,
        .blocks_sent    (blocks_sent),
        .underrun_words (underrun_words)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        okClk = 1'b0;
        forever #5 okClk = ~okClk;
    end

    // ---------------- FIFO model ----------------
    logic [31:0] fifo_q[$];
    logic        ovr_en;
    logic [9:0]  ovr_cnt;
    logic        rd_seen;

    int checks = 0;
    int errors = 0;

    task automatic upd_fifo();
        fifo_empty    = (fifo_q.size() == 0);
        fifo_rd_count = ovr_en ? ovr_cnt : 10'(fifo_q.size());
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
        upd_fifo();
    endtask

    // Starts at posedge+2 and ends at posedge+2 of the next cycle.
    // fifo_rd_en is sampled after inputs settle, before the edge.
    task automatic tick();
        #1;
        rd_seen = fifo_rd_en;
        @(posedge okClk);
        #1;
        if (rd_seen && fifo_q.size() > 0) begin
            fifo_dout  = fifo_q.pop_front();
            fifo_valid = 1'b1;
        end else begin
            fifo_valid = 1'b0;
        end
        upd_fifo();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // n reads; the first n_valid come from the FIFO as base+i, the rest are
    // expected to be underrun fill words.
    task automatic do_reads(input int n, input logic [31:0] base, input int n_valid,
                            input bit expect_done);
        for (int i = 0; i < n; i++) begin
            ep_read = 1'b1;
            tick();
            chk("rd_en", 32'(rd_seen), 32'(i < n_valid));
            chk("datain", ep_datain, (i < n_valid) ? base + 32'(i) : FILL);
        end
        ep_read = 1'b0;
        if (expect_done) begin
            chk("done_state", 32'(state_dbg), 32'd3);
            chk("block_done", 32'(block_done), 32'd1);
            chk("ready_in_done", 32'(ep_ready), 32'd0);
        end else begin
            chk("still_burst", 32'(state_dbg), 32'd2);
        end
    endtask

    task automatic strobe();
        ep_blockstrobe = 1'b1;
        tick();
        ep_blockstrobe = 1'b0;
        chk("burst_entry", 32'(state_dbg), 32'd2);
        chk("ready_fall", 32'(ep_ready), 32'd0);
    endtask

    // DONE -> IDLE, then one more IDLE cycle with too few words.
    task automatic after_done();
        tick();
        chk("done_pulse_end", 32'(block_done), 32'd0);
        chk("idle_after_done", 32'(state_dbg), 32'd0);
        chk("ready_low_1", 32'(ep_ready), 32'd0);
        tick();
        chk("ready_low_2", 32'(ep_ready), 32'd0);
    endtask

    task automatic clear_flags();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("underrun_clr", 32'(underrun), 32'd0);
        chk("proto_clr", 32'(protocol_err), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n        = 1'b0;
        fifo_dout      = '0;
        fifo_valid     = 1'b0;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        clear_err      = 1'b0;
        ovr_en         = 1'b0;
        ovr_cnt        = '0;
        rd_seen        = 1'b0;
        upd_fifo();
        repeat (2) @(posedge okClk);
        #2;

        // Reset state
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_ready", 32'(ep_ready), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_done", 32'(block_done), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_proto", 32'(protocol_err), 32'd0);
        chk("rst_datain", ep_datain, 32'd0);
        reset_n = 1'b1;
        tick();

        // Threshold 127 vs 128, then a 100-word block with 28 underruns
        push_words(32'h0000_1000, 100);
        ovr_en  = 1'b1;
        ovr_cnt = 10'd127;
        upd_fifo();
        tick();
        tick();
        chk("ready_at_127", 32'(ep_ready), 32'd0);
        chk("idle_at_127", 32'(state_dbg), 32'd0);
        ovr_cnt = 10'd128;
        upd_fifo();
        tick();
        chk("ready_at_128", 32'(ep_ready), 32'd1);
        chk("armed_at_128", 32'(state_dbg), 32'd1);
        ovr_en = 1'b0;
        upd_fifo();
        strobe();
        do_reads(128, 32'h0000_1000, 100, 1'b1);
        chk("underrun_set", 32'(underrun), 32'd1);
        after_done();
        chk("datain_holds", ep_datain, FILL);
`ifdef PIPE_OUT_BLOCK_STATS_EN
        chk("underrun_words", 32'(underrun_words), 32'd28);
        chk("blocks_sent_1", 32'(blocks_sent), 32'd1);
`endif
        clear_flags();

        // Clean block of 0x00..0x7F
        push_words(32'h0000_0000, 128);
        tick();
        chk("clean_armed", 32'(ep_ready), 32'd1);
        strobe();
        do_reads(128, 32'h0000_0000, 128, 1'b1);
        chk("clean_no_underrun", 32'(underrun), 32'd0);
        after_done();

        // Protocol violations
        ep_read = 1'b1;
        tick();
        ep_read = 1'b0;
        chk("idle_read_no_rd_en", 32'(rd_seen), 32'd0);
        chk("idle_read_proto", 32'(protocol_err), 32'd1);
        chk("idle_read_state", 32'(state_dbg), 32'd0);
        clear_err = 1'b1;
        ep_read   = 1'b1;
        tick();
        clear_err = 1'b0;
        ep_read   = 1'b0;
        chk("set_beats_clear", 32'(protocol_err), 32'd1);
        clear_flags();
        push_words(32'h0000_2000, 128);
        tick();
        strobe();
        do_reads(5, 32'h0000_2000, 5, 1'b0);
        ep_blockstrobe = 1'b1;
        tick();
        ep_blockstrobe = 1'b0;
        chk("burst_strobe_proto", 32'(protocol_err), 32'd1);
        chk("burst_strobe_state", 32'(state_dbg), 32'd2);
        // Counter must be untouched: exactly 123 more reads finish the block.
        do_reads(122, 32'h0000_2005, 122, 1'b0);
        do_reads(1, 32'h0000_207F, 1, 1'b1);
        after_done();
`ifdef PIPE_OUT_BLOCK_STATS_EN
        chk("blocks_sent_3", 32'(blocks_sent), 32'd3);
`endif
        clear_flags();

        // Reset in the middle of a burst
        push_words(32'h0000_3000, 128);
        tick();
        strobe();
        do_reads(50, 32'h0000_3000, 50, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_dbg), 32'd0);
        chk("mid_rst_ready", 32'(ep_ready), 32'd0);
        chk("mid_rst_done", 32'(block_done), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        chk("mid_rst_proto", 32'(protocol_err), 32'd0);
        chk("mid_rst_datain", ep_datain, 32'd0);
        fifo_q.delete();
        fifo_valid = 1'b0;
        upd_fifo();
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge okClk);
        #2;
        reset_n = 1'b1;
        push_words(32'h0000_4000, 128);
        tick();
        chk("post_rst_armed", 32'(ep_ready), 32'd1);
        strobe();
        do_reads(128, 32'h0000_4000, 128, 1'b1);
        after_done();
        chk("post_rst_underrun", 32'(underrun), 32'd0);
        chk("post_rst_proto", 32'(protocol_err), 32'd0);
`ifdef PIPE_OUT_BLOCK_STATS_EN
        chk("blocks_sent_after_rst", 32'(blocks_sent), 32'd1);
        chk("underrun_words_after_rst", 32'(underrun_words), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
